// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with a valid/ready stream interface.
// Supports logical shift, arithmetic shift and rotate in both directions.
// Stage k applies a 2^k step when bit k of the carried amount is set.
// The last stage is the output register, so latency is $clog2(WIDTH) cycles.
// A single global advance signal moves the whole pipeline or holds it.
// Optional feature macro: SHIFT_FLAGS_EN adds the out_zero and out_carry flags.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SH_W = $clog2(WIDTH),
  localparam int LAT  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 4");
  end

  // One pipeline step: shift/rotate by 2^s when bit s of the amount is set.
  // Arithmetic right uses the current MSB, which always equals the original
  // sign bit because every earlier arithmetic step preserved it.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] d,
    input logic [SH_W-1:0]  amt,
    input logic             dir,
    input logic [1:0]       op,
    input int unsigned      s
  );
    logic [WIDTH-1:0] r;
    int unsigned      sh;
    sh = 32'd1 << s;
    r  = d;
    if (amt[s]) begin
      case (op)
        2'b10:   r = dir ? ((d >> sh) | (d << (WIDTH - sh)))
                         : ((d << sh) | (d >> (WIDTH - sh)));
        2'b01:   r = dir ? $unsigned($signed(d) >>> sh) : (d << sh);
        default: r = dir ? (d >> sh) : (d << sh);
      endcase
    end
    return r;
  endfunction

  logic [WIDTH-1:0] r_data [LAT];
  logic [SH_W-1:0]  r_amt  [LAT];
  logic             r_dir  [LAT];
  logic [1:0]       r_op   [LAT];
  logic [TAG_W-1:0] r_tag  [LAT];
  logic             r_vld  [LAT];

  logic             w_adv;
  logic [WIDTH-1:0] w_next [LAT];

  assign w_adv     = !r_vld[LAT-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[LAT-1];
  assign out_data  = r_data[LAT-1];
  assign out_tag   = r_tag[LAT-1];

  // Next data value for every stage: stage 0 from the input port, others from the previous stage.
  always_comb begin
    w_next[0] = f_step(in_data, in_amt, in_dir, in_op, 0);
    for (int unsigned k = 1; k < LAT; k++) begin
      w_next[k] = f_step(r_data[k-1], r_amt[k-1], r_dir[k-1], r_op[k-1], k);
    end
  end

  // Pipeline registers: all stages advance together or all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_dir[k]  <= 1'b0;
        r_op[k]   <= '0;
        r_tag[k]  <= '0;
        r_vld[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      r_data[0] <= w_next[0];
      r_amt[0]  <= in_amt;
      r_dir[0]  <= in_dir;
      r_op[0]   <= in_op;
      r_tag[0]  <= in_tag;
      r_vld[0]  <= in_valid;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_data[k] <= w_next[k];
        r_amt[k]  <= r_amt[k-1];
        r_dir[k]  <= r_dir[k-1];
        r_op[k]   <= r_op[k-1];
        r_tag[k]  <= r_tag[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic             r_carry [LAT];
  logic             r_zero;
  logic             w_carry;
  logic [SH_W-1:0]  w_lidx;

  // WIDTH is a power of two, so WIDTH - amt reduces to the negated amount.
  assign w_lidx    = '0 - in_amt;
  assign out_zero  = r_zero;
  assign out_carry = r_carry[LAT-1];

  // Last bit shifted out, taken from the original operand at acceptance.
  always_comb begin
    w_carry = 1'b0;
    if (in_op != 2'b10 && in_amt != '0) begin
      w_carry = in_dir ? in_data[in_amt - 1'b1] : in_data[w_lidx];
    end
  end

  // Flag registers travel with the data and hold under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        r_carry[k] <= 1'b0;
      end
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_carry[0] <= w_carry;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_carry[k] <= r_carry[k-1];
      end
      r_zero <= (w_next[LAT-1] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter at WIDTH = 8.
// Expected results come from a whole-amount arithmetic reference model and a
// queue of accepted operations; directed cases use hand-derived constants.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [2:0]    in_amt;
  logic          in_dir;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef SHIFT_FLAGS_EN
  logic          out_zero;
  logic          out_carry;
`endif

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef SHIFT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          carry;
  } exp_t;

  exp_t          q[$];
  int            checks   = 0;
  int            failures = 0;
  bit            stall_prev = 1'b0;
  logic [W-1:0]  prev_data;
  logic [TW-1:0] prev_tag;
  logic [W-1:0]  last_data;
  logic [TW-1:0] last_tag;
  logic          last_zero;
  logic          last_carry;
  logic          last_in_ready;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Reference: the whole shift in one go, plain integer arithmetic.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a,
                                             input bit dir, input logic [1:0] op);
    int unsigned v;
    int          sv;
    int unsigned mask;
    v    = d;
    mask = (1 << W) - 1;
    if (a == 0) return d;
    if (op == 2'b10) begin
      if (dir) return W'(((v >> a) | (v << (W - a))) & mask);
      else     return W'(((v << a) | (v >> (W - a))) & mask);
    end
    if (op == 2'b01 && dir) begin
      sv = int'(v) - (d[W-1] ? (1 << W) : 0);
      return W'((sv >>> a) & int'(mask));
    end
    if (dir) return W'(v >> a);
    return W'((v << a) & mask);
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] d, input int a,
                                     input bit dir, input logic [1:0] op);
    int unsigned v;
    v = d;
    if (op == 2'b10 || a == 0) return 1'b0;
    if (dir) return 1'((v >> (a - 1)) & 1);
    return 1'((v >> (W - a)) & 1);
  endfunction

  // One clock cycle: drive inputs, check the output side, record acceptance.
  task automatic step(input bit v, input logic [W-1:0] d, input logic [2:0] a,
                      input bit dir, input logic [1:0] op, input logic [TW-1:0] tag,
                      input bit ordy, output bit acc, output bit got);
    exp_t e;
    in_valid = v; in_data = d; in_amt = a; in_dir = dir; in_op = op; in_tag = tag;
    out_ready = ordy;
    #1;
    last_in_ready = in_ready;
    chk("in_ready_rule", in_ready, (!out_valid || ordy));
    if (stall_prev) begin
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_data", out_data, prev_data);
      chk("stall_hold_tag", out_tag, prev_tag);
    end
    got = 1'b0;
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_tag", out_tag, e.tag);
`ifdef SHIFT_FLAGS_EN
        chk("out_zero", out_zero, (e.data == 0));
        chk("out_carry", out_carry, e.carry);
        last_zero  = out_zero;
        last_carry = out_carry;
`endif
        last_data = out_data;
        last_tag  = out_tag;
        got = 1'b1;
      end
    end
    acc = v && in_ready;
    if (acc) begin
      e.data  = ref_shift(d, int'(a), dir, op);
      e.tag   = tag;
      e.carry = ref_carry(d, int'(a), dir, op);
      q.push_back(e);
    end
    stall_prev = out_valid && !ordy;
    prev_data  = out_data;
    prev_tag   = out_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string nm, input logic [W-1:0] d, input logic [2:0] a,
                          input bit dir, input logic [1:0] op, input logic [TW-1:0] tag,
                          input logic [W-1:0] exp_d);
    bit acc, got;
    int lat;
    step(1'b1, d, a, dir, op, tag, 1'b1, acc, got);
    chk({nm, "_accept"}, acc, 1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      step(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b1, acc, got);
      lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_data"}, last_data, exp_d);
    chk({nm, "_tag"}, last_tag, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, got;
    int idx, ngot, guard;
    bit ordy;
    logic [W-1:0] sd [8];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0;
    in_op = 2'b00; in_tag = '0; out_ready = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_tag", out_tag, 0);
`ifdef SHIFT_FLAGS_EN
    chk("reset_out_zero", out_zero, 0);
    chk("reset_out_carry", out_carry, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from hand-derived values
    directed("lsl_81_3", 8'h81, 3'd3, 1'b0, 2'b00, 4'd5, 8'h08);
    directed("asr_90_2", 8'h90, 3'd2, 1'b1, 2'b01, 4'd1, 8'hE4);
    directed("lsr_90_2", 8'h90, 3'd2, 1'b1, 2'b00, 4'd2, 8'h24);
    directed("rol_81_1", 8'h81, 3'd1, 1'b0, 2'b10, 4'd3, 8'h03);
    directed("ror_81_0", 8'h81, 3'd0, 1'b1, 2'b10, 4'd4, 8'h81);
    directed("ror_01_7", 8'h01, 3'd7, 1'b1, 2'b10, 4'd6, 8'h02);
    directed("asl_c1_2", 8'hC1, 3'd2, 1'b0, 2'b01, 4'd7, 8'h04);
    directed("rsv_f0_4", 8'hF0, 3'd4, 1'b1, 2'b11, 4'd8, 8'h0F);
`ifdef SHIFT_FLAGS_EN
    directed("flag_lsr_03_2", 8'h03, 3'd2, 1'b1, 2'b00, 4'd9, 8'h00);
    chk("flag_lsr_zero", last_zero, 1);
    chk("flag_lsr_carry", last_carry, 1);
    directed("flag_rol_80_1", 8'h80, 3'd1, 1'b0, 2'b10, 4'd10, 8'h01);
    chk("flag_rol_carry", last_carry, 0);
`endif

    // Eight back-to-back ops, output stalled on cycles 4-6
    for (int i = 0; i < 8; i++) sd[i] = W'($urandom);
    idx = 0;
    ngot = 0;
    for (int c = 0; c < 40; c++) begin
      ordy = !(c >= 4 && c <= 6);
      if (idx < 8)
        step(1'b1, sd[idx], 3'(idx), idx[0], 2'(idx % 3), 4'(idx), ordy, acc, got);
      else
        step(1'b0, '0, '0, 1'b0, 2'b00, '0, ordy, acc, got);
      if (c == 4) chk("stall_in_ready_low", last_in_ready, 0);
      if (acc) idx++;
      if (got) ngot++;
    end
    chk("stall_all_accepted", idx, 8);
    chk("stall_all_emerged", ngot, 8);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 4'(i), 1'b1, acc, got);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b1, acc, got);
      chk("post_reset_no_valid", out_valid, 0);
    end

    // Randomized traffic with random backpressure and bubbles
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), 3'($urandom), 1'($urandom),
           2'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7), acc, got);
    end
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      step(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b1, acc, got);
      guard++;
    end
    chk("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
